// File: rtl/i2c_slave.sv
// I2C target: filtered SCL/SDA, START/STOP detect, 7-bit address match, byte write and tx_req-driven read path.
// Optional macro I2C_GENERAL_CALL_EN: also ACK general-call writes (7'h00, W) and add the gc_active output.
//
// state    | meaning
// IDLE     | bus ignored until START (also the post-NACK / no-match wait)
// ADDR     | shifting 7 address bits plus R/W
// ADDR_ACK | phase 0: wait for fall; phase 1: ACK driven, next fall enters data phase
// WR_DATA  | shifting a byte written by the master
// WR_ACK   | phase 0: wait for fall; phase 1: ACK driven until next fall
// RD_DATA  | driving read bits on each fall; phase 1: byte load from tx_data pending
// RD_ACK   | sampling master ACK/NACK
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h48,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
`ifdef I2C_GENERAL_CALL_EN
    output logic       gc_active,
`endif
    output logic       addr_match
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0] sync1, sync2, filt, filt_d;
    logic [2:0] flt_cnt [2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            filt_d     <= 2'b11;
            flt_cnt[0] <= 3'd0;
            flt_cnt[1] <= 3'd0;
        end else begin
            sync1  <= {scl, sda};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= 3'd0;
                end else if (flt_cnt[i] == FLT_MAX) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= 3'd0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 3'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_p, sda_p;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_p    = filt_d[1];
    assign sda_p    = filt_d[0];
    assign scl_rise = scl_f & ~scl_p;
    assign scl_fall = ~scl_f & scl_p;
    // SCL must be high on both samples so a coincident SCL edge never reads as START/STOP
    assign start_cond = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_cond  = scl_f & scl_p & ~sda_p & sda_f;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic       phase, phase_nxt;
    logic       rw, rw_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, tx_req_nxt, start_det_nxt, stop_det_nxt;
    logic       busy_nxt, addr_match_nxt;
    logic [7:0] byte_in;
    logic       addr_ok;

    assign byte_in = {shreg, sda_f};
    assign sda     = sda_oe ? 1'b0 : 1'bz;

`ifdef I2C_GENERAL_CALL_EN
    logic gc_sel;

    assign addr_ok = (byte_in[7:1] == SLAVE_ADDR) || (byte_in == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            gc_sel    <= 1'b0;
            gc_active <= 1'b0;
        end else if (start_cond || stop_cond) begin
            gc_sel    <= 1'b0;
            gc_active <= 1'b0;
        end else if (state == ADDR && scl_rise && bit_cnt == 3'd0) begin
            gc_sel <= (byte_in == 8'h00);
        end else if (state == ADDR_ACK && scl_fall && !phase && gc_sel) begin
            gc_active <= 1'b1;
        end
    end
`else
    assign addr_ok = (byte_in[7:1] == SLAVE_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd7;
            shreg      <= 7'd0;
            phase      <= 1'b0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            phase      <= phase_nxt;
            rw         <= rw_nxt;
            sda_oe     <= sda_oe_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            tx_req     <= tx_req_nxt;
            start_det  <= start_det_nxt;
            stop_det   <= stop_det_nxt;
            busy       <= busy_nxt;
            addr_match <= addr_match_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        phase_nxt      = phase;
        rw_nxt         = rw;
        sda_oe_nxt     = sda_oe;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        tx_req_nxt     = 1'b0;
        start_det_nxt  = 1'b0;
        stop_det_nxt   = 1'b0;
        busy_nxt       = busy;
        addr_match_nxt = addr_match;

        if (start_cond) begin
            state_nxt      = ADDR;
            bit_cnt_nxt    = 3'd7;
            phase_nxt      = 1'b0;
            sda_oe_nxt     = 1'b0;
            start_det_nxt  = 1'b1;
            busy_nxt       = 1'b0;
            addr_match_nxt = 1'b0;
        end else if (stop_cond) begin
            state_nxt      = IDLE;
            bit_cnt_nxt    = 3'd7;
            phase_nxt      = 1'b0;
            sda_oe_nxt     = 1'b0;
            stop_det_nxt   = 1'b1;
            busy_nxt       = 1'b0;
            addr_match_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_nxt   = byte_in[6:0];
                    // decrement wraps 0 -> 7, reloading the counter at the byte boundary
                    bit_cnt_nxt = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        rw_nxt    = sda_f;
                        phase_nxt = 1'b0;
                        if (addr_ok) begin
                            state_nxt      = ADDR_ACK;
                            addr_match_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        phase_nxt  = 1'b1;
                        sda_oe_nxt = 1'b1;
                        busy_nxt   = 1'b1;
                        tx_req_nxt = rw;
                    end else begin
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = 3'd7;
                        if (rw) begin
                            shreg_nxt  = tx_data[6:0];
                            sda_oe_nxt = ~tx_data[7];
                            state_nxt  = RD_DATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = WR_DATA;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_nxt   = byte_in[6:0];
                    bit_cnt_nxt = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        rx_data_nxt  = byte_in;
                        rx_valid_nxt = 1'b1;
                        phase_nxt    = 1'b0;
                        state_nxt    = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        phase_nxt  = 1'b1;
                        sda_oe_nxt = 1'b1;
                    end else begin
                        phase_nxt  = 1'b0;
                        sda_oe_nxt = 1'b0;
                        state_nxt  = WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (phase) begin
                        shreg_nxt   = tx_data[6:0];
                        sda_oe_nxt  = ~tx_data[7];
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = 3'd7;
                    end else if (bit_cnt == 3'd0) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 3'd7;
                        state_nxt   = RD_ACK;
                    end else begin
                        shreg_nxt   = {shreg[5:0], 1'b0};
                        sda_oe_nxt  = ~shreg[6];
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_f) begin
                        tx_req_nxt = 1'b1;
                        phase_nxt  = 1'b1;
                        state_nxt  = RD_DATA;
                    end else begin
                        sda_oe_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on an open-drain bus, checked against hand-computed values.
module tb_i2c_slave;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst, m_scl, m_sda;
    wire  sda;
    logic [7:0] rx_data, tx_data;
    logic rx_valid, tx_req, start_det, stop_det, busy, addr_match;
`ifdef I2C_GENERAL_CALL_EN
    logic gc_active;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, am_cnt = 0, slave_low = 0;
    int b_rx, b_tx, b_start, b_stop, b_am, b_low;
    logic [7:0] rx_last = 8'h00, rx_prev = 8'h00;
    logic [7:0] tx_list [5] = '{8'h00, 8'h81, 8'h7E, 8'hC3, 8'hEF};
    logic       ack, rb;
    logic [7:0] d;

    always #5 clk = ~clk;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);
    assign tx_data = (tx_cnt < 5) ? tx_list[tx_cnt] : 8'h00;

    i2c_slave #(.SLAVE_ADDR(7'h48), .FILTER_LEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (m_scl),
        .sda        (sda),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy),
`ifdef I2C_GENERAL_CALL_EN
        .gc_active  (gc_active),
`endif
        .addr_match (addr_match)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_prev <= rx_last;
            rx_last <= rx_data;
        end
        if (tx_req)     tx_cnt    <= tx_cnt + 1;
        if (start_det)  start_cnt <= start_cnt + 1;
        if (stop_det)   stop_cnt  <= stop_cnt + 1;
        if (addr_match) am_cnt    <= am_cnt + 1;
        if (m_sda && sda === 1'b0) slave_low <= slave_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_rx = rx_cnt; b_tx = tx_cnt; b_start = start_cnt;
        b_stop = stop_cnt; b_am = am_cnt; b_low = slave_low;
    endtask

    task automatic bit_io(input logic b, input logic glitch, output logic r);
        m_sda = b;
        if (glitch) begin
            wait_clk(Q / 2);
            m_scl = 1'b1;
            wait_clk(1);
            m_scl = 1'b0;
            wait_clk(Q - Q / 2 - 1);
        end else begin
            wait_clk(Q);
        end
        m_scl = 1'b1;
        wait_clk(Q);
        r = sda;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] v, input int gbit, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(v[i], i == gbit, r);
        bit_io(1'b1, 1'b0, a);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, 1'b0, r);
            v[i] = r;
        end
        bit_io(nack, 1'b0, r);
    endtask

    task automatic start_c();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(5);
        chk("rst_rx_data",   32'(rx_data),    0);
        chk("rst_rx_valid",  32'(rx_valid),   0);
        chk("rst_tx_req",    32'(tx_req),     0);
        chk("rst_start_det", 32'(start_det),  0);
        chk("rst_stop_det",  32'(stop_det),   0);
        chk("rst_busy",      32'(busy),       0);
        chk("rst_addr_match",32'(addr_match), 0);
        chk("rst_sda",       32'(sda),        1);
        rst = 1'b1;
        wait_clk(5);

        // write 0x48: A5, 3C
        snap();
        start_c();
        wr_byte(8'h90, -1, ack); chk("w1_addr_ack", 32'(ack), 0);
        chk("w1_busy_mid",  32'(busy),       1);
        chk("w1_match_mid", 32'(addr_match), 1);
        wr_byte(8'hA5, -1, ack); chk("w1_d0_ack", 32'(ack), 0);
        wr_byte(8'h3C, -1, ack); chk("w1_d1_ack", 32'(ack), 0);
        stop_c();
        wait_clk(Q);
        chk("w1_rx_count", 32'(rx_cnt - b_rx),       2);
        chk("w1_rx_first", 32'(rx_prev),             'hA5);
        chk("w1_rx_last",  32'(rx_last),             'h3C);
        chk("w1_starts",   32'(start_cnt - b_start), 1);
        chk("w1_stops",    32'(stop_cnt - b_stop),   1);
        chk("w1_busy_end", 32'(busy),                0);

        // write to foreign address 0x21
        snap();
        start_c();
        wr_byte(8'h42, -1, ack); chk("w2_addr_nack", 32'(ack), 1);
        wr_byte(8'h55, -1, ack); chk("w2_data_nack", 32'(ack), 1);
        stop_c();
        wait_clk(Q);
        chk("w2_rx_count",  32'(rx_cnt - b_rx),       0);
        chk("w2_match",     32'(am_cnt - b_am),       0);
        chk("w2_slave_low", 32'(slave_low - b_low),   0);

        // read 2 bytes from 0x48
        snap();
        start_c();
        wr_byte(8'h91, -1, ack); chk("r1_addr_ack", 32'(ack), 0);
        rd_byte(1'b0, d); chk("r1_d0", 32'(d), 'h81);
        rd_byte(1'b1, d); chk("r1_d1", 32'(d), 'h7E);
        chk("r1_released", 32'(sda), 1);
        stop_c();
        wait_clk(Q);
        chk("r1_tx_req_count", 32'(tx_cnt - b_tx), 2);

        // write 0x10, repeated START, read 1 byte
        snap();
        start_c();
        wr_byte(8'h90, -1, ack); chk("rs_waddr_ack", 32'(ack), 0);
        wr_byte(8'h10, -1, ack); chk("rs_wdata_ack", 32'(ack), 0);
        start_c();
        wr_byte(8'h91, -1, ack); chk("rs_raddr_ack", 32'(ack), 0);
        rd_byte(1'b1, d); chk("rs_rdata", 32'(d), 'hC3);
        stop_c();
        wait_clk(Q);
        chk("rs_rx_data",  32'(rx_data),             'h10);
        chk("rs_rx_count", 32'(rx_cnt - b_rx),       1);
        chk("rs_starts",   32'(start_cnt - b_start), 2);

        // reset during bit 4 of a read byte (0xEF, bit 4 = 0)
        start_c();
        wr_byte(8'h91, -1, ack); chk("rr_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 3; i++) begin
            bit_io(1'b1, 1'b0, rb);
            chk("rr_hi_bit", 32'(rb), 1);
        end
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q / 2);
        chk("rr_bit4_driven", 32'(sda), 0);
        rst = 1'b0;
        wait_clk(1);
        chk("rr_sda_release", 32'(sda),        1);
        chk("rr_busy",        32'(busy),       0);
        chk("rr_addr_match",  32'(addr_match), 0);
        chk("rr_rx_data",     32'(rx_data),    0);
        chk("rr_tx_req",      32'(tx_req),     0);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(Q / 2);
        m_scl = 1'b0; wait_clk(Q);
        stop_c();
        start_c();
        wr_byte(8'h90, -1, ack); chk("rr_w_addr_ack", 32'(ack), 0);
        wr_byte(8'h99, -1, ack); chk("rr_w_data_ack", 32'(ack), 0);
        stop_c();
        wait_clk(Q);
        chk("rr_w_rx_data", 32'(rx_last), 'h99);

        // 1-cycle SCL glitch in the low phase of data bit 3
        snap();
        start_c();
        wr_byte(8'h90, -1, ack); chk("gl_addr_ack", 32'(ack), 0);
        wr_byte(8'h5A, 3, ack);  chk("gl_data_ack", 32'(ack), 0);
        stop_c();
        wait_clk(Q);
        chk("gl_rx_data",  32'(rx_last),       'h5A);
        chk("gl_rx_count", 32'(rx_cnt - b_rx), 1);

        // general-call address 0x00 write
        snap();
        start_c();
`ifdef I2C_GENERAL_CALL_EN
        wr_byte(8'h00, -1, ack); chk("gc_addr_ack", 32'(ack), 0);
        chk("gc_active_on", 32'(gc_active), 1);
        wr_byte(8'h06, -1, ack); chk("gc_data_ack", 32'(ack), 0);
        stop_c();
        wait_clk(Q);
        chk("gc_rx_data",    32'(rx_last),   'h06);
        chk("gc_active_off", 32'(gc_active), 0);
`else
        wr_byte(8'h00, -1, ack); chk("gc_addr_nack", 32'(ack), 1);
        stop_c();
        wait_clk(Q);
        chk("gc_rx_count", 32'(rx_cnt - b_rx), 0);
        chk("gc_match",    32'(am_cnt - b_am), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
